// File: rtl/axi_lite_ipif_bridge_pkg.sv
// Shared definitions for the AXI4-Lite to IPIF bridge: response codes and FSM states.
package axi_lite_ipif_bridge_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/axi_lite_ipif_bridge_dphase_timer.sv
// Data-phase watchdog: loaded as the access strobe rises, counts while it is held,
// flags expiry on the last permitted cycle.
module axi_lite_ipif_bridge_dphase_timer #(
  parameter int unsigned TIMEOUT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(TIMEOUT - 1);
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expired_c = i_en && (r_cnt == '0);

endmodule

// File: rtl/axi_lite_ipif_bridge.sv
// AXI4-Lite slave to IPIF master bridge with a single outstanding access,
// address window decode and data-phase timeout.
module axi_lite_ipif_bridge
  import axi_lite_ipif_bridge_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter logic [31:0] C_BASEADDR         = 32'hFFFF_FFFF,
  parameter logic [31:0] C_HIGHADDR         = 32'h0000_0000,
  parameter int unsigned C_DPHASE_TIMEOUT   = 32
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              Bus2IP_Resetn,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]     Bus2IP_Addr,
  output logic                              Bus2IP_CS,
  output logic                              Bus2IP_RNW,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     Bus2IP_Data,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0]   Bus2IP_BE,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     IP2Bus_Data,
  input  logic                              IP2Bus_RdAck,
  input  logic                              IP2Bus_WrAck,
  input  logic                              IP2Bus_Error
);

  localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned BW = C_S_AXI_DATA_WIDTH / 8;

  state_e          r_state, w_state_nxt;
  logic            r_wr_rdy, w_wr_rdy_nxt;
  logic            r_ar_rdy, w_ar_rdy_nxt;
  logic            r_cs, w_cs_nxt;
  logic            r_rnw, w_rnw_nxt;
  logic [AW-1:0]   r_addr, w_addr_nxt;
  logic [DW-1:0]   r_wdata, w_wdata_nxt;
  logic [BW-1:0]   r_be, w_be_nxt;
  logic [DW-1:0]   r_rdata, w_rdata_nxt;
  logic [1:0]      r_resp, w_resp_nxt;
  logic            r_bvalid, w_bvalid_nxt;
  logic            r_rvalid, w_rvalid_nxt;
  logic            r_last_rd, w_last_rd_nxt;
  logic            r_done, w_done_nxt;
  logic            r_resetn;
  logic            w_timer_load;
  logic            w_expired_c;
  logic            w_wr_req, w_grant_rd, w_ack, w_in_range;
  logic [AW:0]     w_lo_diff, w_hi_diff;

  assign w_wr_req   = S_AXI_AWVALID && S_AXI_WVALID;
  // Alternate when both directions are pending; otherwise serve whichever is present.
  assign w_grant_rd = S_AXI_ARVALID && (!w_wr_req || !r_last_rd);
  assign w_ack      = r_rnw ? IP2Bus_RdAck : IP2Bus_WrAck;

  // Borrow out of each subtraction means the latched address lies outside the window.
  assign w_lo_diff  = {1'b0, r_addr} - {1'b0, AW'(C_BASEADDR)};
  assign w_hi_diff  = {1'b0, AW'(C_HIGHADDR)} - {1'b0, r_addr};
  assign w_in_range = !w_lo_diff[AW] && !w_hi_diff[AW];

  axi_lite_ipif_bridge_dphase_timer #(
    .TIMEOUT (C_DPHASE_TIMEOUT)
  ) u_timer (
    .clk         (S_AXI_ACLK),
    .rst         (S_AXI_ARESET),
    .i_load      (w_timer_load),
    .i_en        (r_cs),
    .o_expired_c (w_expired_c)
  );

  always_ff @(posedge S_AXI_ACLK) begin
    r_resetn <= ~S_AXI_ARESET;
    if (S_AXI_ARESET) begin
      r_state   <= ST_IDLE;
      r_wr_rdy  <= 1'b0;
      r_ar_rdy  <= 1'b0;
      r_cs      <= 1'b0;
      r_rnw     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_rdata   <= '0;
      r_resp    <= RESP_OKAY;
      r_bvalid  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_last_rd <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_rdy  <= w_wr_rdy_nxt;
      r_ar_rdy  <= w_ar_rdy_nxt;
      r_cs      <= w_cs_nxt;
      r_rnw     <= w_rnw_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_be      <= w_be_nxt;
      r_rdata   <= w_rdata_nxt;
      r_resp    <= w_resp_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_last_rd <= w_last_rd_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_wr_rdy_nxt  = 1'b0;
    w_ar_rdy_nxt  = 1'b0;
    w_cs_nxt      = r_cs;
    w_rnw_nxt     = r_rnw;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_be_nxt      = r_be;
    w_rdata_nxt   = r_rdata;
    w_resp_nxt    = r_resp;
    w_bvalid_nxt  = r_bvalid;
    w_rvalid_nxt  = r_rvalid;
    w_last_rd_nxt = r_last_rd;
    w_done_nxt    = r_done;
    w_timer_load  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_rd) begin
          w_ar_rdy_nxt  = 1'b1;
          w_rnw_nxt     = 1'b1;
          w_addr_nxt    = S_AXI_ARADDR;
          w_last_rd_nxt = 1'b1;
          w_done_nxt    = 1'b0;
          w_state_nxt   = ST_ACCESS;
        end else if (w_wr_req) begin
          w_wr_rdy_nxt  = 1'b1;
          w_rnw_nxt     = 1'b0;
          w_addr_nxt    = S_AXI_AWADDR;
          w_wdata_nxt   = S_AXI_WDATA;
          w_be_nxt      = S_AXI_WSTRB;
          w_last_rd_nxt = 1'b0;
          w_done_nxt    = 1'b0;
          w_state_nxt   = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // First ACCESS cycle carries the READY pulse; the strobe follows it.
        if (r_wr_rdy || r_ar_rdy) begin
          if (w_in_range) begin
            w_cs_nxt     = 1'b1;
            w_timer_load = 1'b1;
          end else begin
            w_resp_nxt   = RESP_DECERR;
            w_rdata_nxt  = '0;
            w_bvalid_nxt = !r_rnw;
            w_rvalid_nxt = r_rnw;
            w_state_nxt  = ST_RESP;
          end
        end else if (r_done) begin
          w_done_nxt   = 1'b0;
          w_bvalid_nxt = !r_rnw;
          w_rvalid_nxt = r_rnw;
          w_state_nxt  = ST_RESP;
        end else if (r_cs) begin
          if (w_ack) begin
            w_cs_nxt   = 1'b0;
            w_done_nxt = 1'b1;
            w_resp_nxt = IP2Bus_Error ? RESP_SLVERR : RESP_OKAY;
            if (r_rnw) begin
              w_rdata_nxt = IP2Bus_Data;
            end
          end else if (w_expired_c) begin
            w_cs_nxt    = 1'b0;
            w_done_nxt  = 1'b1;
            w_resp_nxt  = RESP_SLVERR;
            w_rdata_nxt = '0;
          end
        end
      end
      ST_RESP: begin
        if ((r_bvalid && S_AXI_BREADY) || (r_rvalid && S_AXI_RREADY)) begin
          w_bvalid_nxt = 1'b0;
          w_rvalid_nxt = 1'b0;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign S_AXI_AWREADY = r_wr_rdy;
  assign S_AXI_WREADY  = r_wr_rdy;
  assign S_AXI_ARREADY = r_ar_rdy;
  assign S_AXI_BRESP   = r_bvalid ? r_resp : RESP_OKAY;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rvalid ? r_resp : RESP_OKAY;
  assign S_AXI_RVALID  = r_rvalid;
  assign Bus2IP_Resetn = r_resetn;
  assign Bus2IP_Addr   = r_addr;
  assign Bus2IP_CS     = r_cs;
  assign Bus2IP_RNW    = r_rnw;
  assign Bus2IP_Data   = r_wdata;
  assign Bus2IP_BE     = r_be;

endmodule

// File: tb/tb_axi_lite_ipif_bridge.sv
// Randomized scoreboard bench for axi_lite_ipif_bridge with a transaction-level response model.
module tb_axi_lite_ipif_bridge;

  localparam int unsigned T    = 32;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] HIGH = 32'h0000_0FFF;

  typedef struct packed {
    logic        is_rd;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] aw_addr = '0, w_data = '0, ar_addr = '0, ip_data = '0;
  logic [3:0]  w_strb = '0;
  logic        aw_valid = 1'b0, w_valid = 1'b0, ar_valid = 1'b0;
  logic        bready = 1'b0, rready = 1'b0;
  logic        ip_rdack = 1'b0, ip_wrack = 1'b0, ip_err = 1'b0;
  logic        aw_ready, w_ready, ar_ready, bvalid, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, bus_addr, bus_data;
  logic [3:0]  bus_be;
  logic        bus_resetn, bus_cs, bus_rnw;

  int   checks = 0, errors = 0, cyc = 0, vld_cyc = 0;
  bit   prev_vld = 1'b0, last_rd = 1'b0;
  exp_t sb[$];

  axi_lite_ipif_bridge #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (32),
    .C_BASEADDR         (BASE),
    .C_HIGHADDR         (HIGH),
    .C_DPHASE_TIMEOUT   (T)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .S_AXI_AWADDR  (aw_addr),
    .S_AXI_AWVALID (aw_valid),
    .S_AXI_AWREADY (aw_ready),
    .S_AXI_WDATA   (w_data),
    .S_AXI_WSTRB   (w_strb),
    .S_AXI_WVALID  (w_valid),
    .S_AXI_WREADY  (w_ready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (ar_addr),
    .S_AXI_ARVALID (ar_valid),
    .S_AXI_ARREADY (ar_ready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .Bus2IP_Resetn (bus_resetn),
    .Bus2IP_Addr   (bus_addr),
    .Bus2IP_CS     (bus_cs),
    .Bus2IP_RNW    (bus_rnw),
    .Bus2IP_Data   (bus_data),
    .Bus2IP_BE     (bus_be),
    .IP2Bus_Data   (ip_data),
    .IP2Bus_RdAck  (ip_rdack),
    .IP2Bus_WrAck  (ip_wrack),
    .IP2Bus_Error  (ip_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle on which a response first became visible.
  always @(negedge clk) begin
    if ((bvalid || rvalid) && !prev_vld) vld_cyc = cyc;
    prev_vld = bvalid || rvalid;
  end

  // Scoreboard monitor: every completed B/R handshake consumes one expected response.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ((bvalid && bready) || (rvalid && rready))) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_resp", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("resp_channel", 32'(rvalid), 32'(e.is_rd));
        chk("resp_code", 32'(rvalid ? rresp : bresp), 32'(e.resp));
        if (e.is_rd) chk("resp_rdata", rdata, e.data);
      end
    end
  end

  // d = ack delay in cycles after the first strobe cycle; d < 0 means the IP never acks.
  task automatic run_access(input bit is_rd, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] be, input int d, input bit err,
                            input logic [31:0] ipd, input int hold);
    exp_t e;
    bit   in_rng, got;
    int   lat, a, n;
    in_rng  = (addr >= BASE) && (addr <= HIGH);
    e.is_rd = is_rd;
    if (!in_rng) begin
      e.resp = 2'b11; e.data = '0; lat = 0;
    end else if (d >= 0 && d < int'(T)) begin
      e.resp = err ? 2'b10 : 2'b00; e.data = is_rd ? ipd : '0; lat = d + 2;
    end else begin
      e.resp = 2'b10; e.data = '0; lat = int'(T) + 1;
    end
    @(posedge clk); #1;
    if (is_rd) begin
      ar_addr = addr; ar_valid = 1'b1;
    end else begin
      aw_addr = addr; w_data = wd; w_strb = be; aw_valid = 1'b1; w_valid = 1'b1;
    end
    got = 1'b0; a = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (is_rd ? ar_ready : (aw_ready && w_ready)) begin
        got = 1'b1; a = cyc;
      end
    end
    chk(is_rd ? "accept_rd" : "accept_wr", 32'(got), 32'd1);
    if (!got) return;
    chk("other_ready", 32'(is_rd ? (aw_ready | w_ready) : ar_ready), 32'd0);
    sb.push_back(e);
    last_rd = is_rd;
    @(posedge clk); #1;
    if (is_rd) ar_valid = 1'b0;
    else begin aw_valid = 1'b0; w_valid = 1'b0; end
    @(negedge clk);
    chk("cs_after_accept", 32'(bus_cs), 32'(in_rng));
    if (in_rng) begin
      chk("rnw", 32'(bus_rnw), 32'(is_rd));
      chk("bus_addr", bus_addr, addr);
      if (!is_rd) begin
        chk("bus_data", bus_data, wd);
        chk("bus_be", 32'(bus_be), 32'(be));
      end
    end
    if (in_rng && d >= 0) begin
      repeat (d) @(posedge clk);
      #1;
      if (is_rd) begin ip_rdack = 1'b1; ip_data = ipd; end
      else ip_wrack = 1'b1;
      ip_err = err;
      @(posedge clk); #1;
      ip_rdack = 1'b0; ip_wrack = 1'b0; ip_err = 1'b0; ip_data = $urandom;
    end
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!(is_rd ? rvalid : bvalid) && n < 200);
    #1;
    chk("resp_valid", 32'(is_rd ? rvalid : bvalid), 32'd1);
    if (!(is_rd ? rvalid : bvalid)) return;
    chk("latency", 32'(vld_cyc), 32'(a + 1 + lat));
    chk("wrong_valid", 32'(is_rd ? bvalid : rvalid), 32'd0);
    chk("cs_low_at_resp", 32'(bus_cs), 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(is_rd ? rvalid : bvalid), 32'd1);
      chk("hold_resp", 32'(is_rd ? rresp : bresp), 32'(e.resp));
      if (is_rd) chk("hold_rdata", rdata, e.data);
    end
    @(posedge clk); #1;
    if (is_rd) rready = 1'b1; else bready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0; bready = 1'b0;
    @(negedge clk);
    chk("valid_drop", 32'(bvalid | rvalid), 32'd0);
  endtask

  // Write and read presented together; the model grants opposite of the last grant.
  task automatic run_pair(input logic [31:0] wa, input logic [31:0] ra, input logic [31:0] wd,
                          input logic [3:0] be, input logic [31:0] ipd, input int d);
    @(posedge clk); #1;
    aw_addr = wa; w_data = wd; w_strb = be; aw_valid = 1'b1; w_valid = 1'b1;
    ar_addr = ra; ar_valid = 1'b1;
    if (last_rd) begin
      run_access(1'b0, wa, wd, be, d, 1'b0, ipd, 0);
      run_access(1'b1, ra, wd, be, d, 1'b0, ipd, 0);
    end else begin
      run_access(1'b1, ra, wd, be, d, 1'b0, ipd, 0);
      run_access(1'b0, wa, wd, be, d, 1'b0, ipd, 0);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return HIGH + 32'd1 + 32'($urandom_range(0, 255)) * 32'd4;
      1:       return HIGH & 32'hFFFF_FFFC;
      2:       return HIGH + 32'd1;
      default: return $urandom & 32'h0000_0FFC;
    endcase
  endfunction

  function automatic int rand_delay();
    case ($urandom_range(0, 5))
      0:       return -1;
      1:       return int'(T) - 1;
      2:       return int'(T);
      default: return int'($urandom_range(0, 6));
    endcase
  endfunction

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen, got;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 32'(aw_ready | w_ready | ar_ready), 32'd0);
    chk("rst_valids", 32'(bvalid | rvalid), 32'd0);
    chk("rst_resps", 32'({bresp, rresp}), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_cs_rnw", 32'({bus_cs, bus_rnw}), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_data", bus_data, 32'd0);
    chk("rst_bus_be", 32'(bus_be), 32'd0);
    chk("rst_resetn", 32'(bus_resetn), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("resetn_release", 32'(bus_resetn), 32'd1);

    // Simultaneous requests from reset: read first, then alternating.
    run_pair(32'h0000_0010, 32'h0000_0020, 32'hA5A5_0001, 4'hF, 32'h0BAD_F00D, 1);
    run_pair(32'h0000_0030, 32'h0000_0040, 32'hA5A5_0002, 4'h3, 32'h1111_2222, 2);

    // Directed transactions: plain write/read, timeouts, boundary ack timing, decode errors.
    run_access(1'b0, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 1, 1'b0, 32'h0, 0);
    run_access(1'b1, 32'h0000_0008, 32'h0, 4'h0, 1, 1'b0, 32'h1234_5678, 0);
    run_access(1'b1, 32'h0000_000C, 32'h0, 4'h0, -1, 1'b0, 32'h0, 0);
    run_access(1'b0, 32'h0000_000C, 32'h0102_0304, 4'h5, -1, 1'b0, 32'h0, 0);
    run_access(1'b1, 32'h0000_0100, 32'h0, 4'h0, int'(T) - 1, 1'b0, 32'hCAFE_0001, 1);
    run_access(1'b1, 32'h0000_0104, 32'h0, 4'h0, int'(T), 1'b0, 32'hCAFE_0002, 1);
    run_access(1'b0, 32'h0000_0108, 32'h5555_AAAA, 4'hC, 3, 1'b1, 32'h0, 2);
    run_access(1'b0, HIGH + 32'd4, 32'h7777_8888, 4'hF, 1, 1'b0, 32'h0, 10);
    run_access(1'b1, HIGH + 32'd1, 32'h0, 4'h0, 1, 1'b0, 32'h9999_9999, 3);
    run_access(1'b1, HIGH & 32'hFFFF_FFFC, 32'h0, 4'h0, 0, 1'b1, 32'h4242_4242, 2);

    // Reset while a write is in its data phase, followed by a stray write ack.
    @(posedge clk); #1;
    aw_addr = 32'h0000_0200; w_data = 32'hFEED_FACE; w_strb = 4'hF; aw_valid = 1'b1; w_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (aw_ready && w_ready) got = 1'b1;
    end
    chk("abort_accept", 32'(got), 32'd1);
    @(posedge clk); #1;
    aw_valid = 1'b0; w_valid = 1'b0;
    @(negedge clk);
    chk("abort_cs_before", 32'(bus_cs), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; ip_wrack = 1'b1;
    @(negedge clk);
    chk("abort_cs", 32'(bus_cs), 32'd0);
    chk("abort_resetn", 32'(bus_resetn), 32'd0);
    chk("abort_valid", 32'(bvalid | rvalid), 32'd0);
    @(posedge clk); #1 ip_wrack = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bvalid || rvalid || bus_cs || aw_ready || ar_ready) seen = 1'b1;
    end
    chk("abort_quiet", 32'(seen), 32'd0);
    chk("abort_resetn_back", 32'(bus_resetn), 32'd1);
    last_rd = 1'b0;
    run_pair(32'h0000_0300, 32'h0000_0304, 32'h1357_9BDF, 4'h9, 32'h2468_ACE0, 1);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      int mode;
      mode = int'($urandom_range(0, 3));
      if (mode == 3)
        run_pair(rand_addr(), rand_addr(), $urandom, 4'($urandom_range(0, 15)), $urandom,
                 int'($urandom_range(0, 4)));
      else
        run_access(mode == 0, rand_addr(), $urandom, 4'($urandom_range(0, 15)), rand_delay(),
                   1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 3)));
    end

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
